// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers returned
// words with their PCs and hands {insn, pc} to decode; flushes and refetches on redirect.
module fetch_stage #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       INSN_W      = 32,
    parameter int unsigned       QUEUE_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INSN_W-1:0] imem_resp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INSN_W-1:0] id_insn,
    output logic [ADDR_W-1:0] id_pc
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Program counter
    logic [ADDR_W-1:0] pc_q, pc_d;

    // PC-tag FIFO: one entry per accepted request awaiting its response
    logic [ADDR_W-1:0] tag_mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  tag_wr_q, tag_wr_d;
    logic [PTR_W-1:0]  tag_rd_q, tag_rd_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;

    // Instruction queue presented to decode
    logic [INSN_W-1:0] iq_insn_q [QUEUE_DEPTH];
    logic [ADDR_W-1:0] iq_pc_q   [QUEUE_DEPTH];
    logic [PTR_W-1:0]  iq_wr_q, iq_wr_d;
    logic [PTR_W-1:0]  iq_rd_q, iq_rd_d;
    logic [CNT_W-1:0]  occ_q, occ_d;

    // Responses still owed to requests issued before the last redirect
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              pop;
    logic              accept;
    logic              resp;
    logic              dropping;
    logic              push;
    logic [CNT_W:0]    in_use;
    logic [ADDR_W-1:0] redirect_aligned;

    // Handshake decode and request credit
    always_comb begin
        pop      = 1'b0;
        resp     = 1'b0;
        dropping = 1'b0;
        push     = 1'b0;
        in_use   = '0;
        imem_req_valid = 1'b0;
        accept   = 1'b0;

        pop      = rst & (occ_q != '0) & id_ready;
        resp     = rst & imem_resp_valid;
        dropping = resp & (drop_cnt_q != '0);
        push     = resp & ~dropping;

        // Buffered words plus in-flight requests, less the word leaving this cycle
        in_use = (CNT_W+1)'(occ_q) + (CNT_W+1)'(outstanding_q) - (CNT_W+1)'(pop);
        imem_req_valid = rst & ~redirect_valid & (in_use < (CNT_W+1)'(QUEUE_DEPTH));
        accept         = imem_req_valid & imem_req_ready;
    end

    assign imem_req_addr    = pc_q;
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);

    // PC and tag FIFO next state
    always_comb begin
        pc_d          = pc_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end else if (accept) begin
            pc_d = pc_q + ADDR_W'(4);
        end

        if (accept) begin
            tag_wr_d = tag_wr_q + PTR_W'(1);
        end
        if (resp) begin
            tag_rd_d = tag_rd_q + PTR_W'(1);
        end
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp);

        // Every request still in flight after a redirect belongs to the old path
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - CNT_W'(resp);
        end else if (dropping) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end
    end

    // Instruction queue next state
    always_comb begin
        iq_wr_d = iq_wr_q;
        iq_rd_d = iq_rd_q;
        occ_d   = occ_q;

        if (redirect_valid) begin
            iq_wr_d = '0;
            iq_rd_d = '0;
            occ_d   = '0;
        end else begin
            if (push) begin
                iq_wr_d = iq_wr_q + PTR_W'(1);
            end
            if (pop) begin
                iq_rd_d = iq_rd_q + PTR_W'(1);
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            outstanding_q <= '0;
            iq_wr_q       <= '0;
            iq_rd_q       <= '0;
            occ_q         <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            outstanding_q <= outstanding_d;
            iq_wr_q       <= iq_wr_d;
            iq_rd_q       <= iq_rd_d;
            occ_q         <= occ_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the counters above
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem_q[tag_wr_q] <= pc_q;
        end
        if (push) begin
            iq_insn_q[iq_wr_q] <= imem_resp_data;
            iq_pc_q[iq_wr_q]   <= tag_mem_q[tag_rd_q];
        end
    end

    // Memory contract: responses only for issued requests, never into a full queue
    always_ff @(posedge clk) begin
        if (rst && resp) begin
            assert (outstanding_q != '0);
        end
        if (rst && push) begin
            assert (occ_q != CNT_W'(QUEUE_DEPTH));
        end
    end

    assign id_valid = rst & (occ_q != '0);
    assign id_insn  = rst ? iq_insn_q[iq_rd_q] : '0;
    assign id_pc    = rst ? iq_pc_q[iq_rd_q]   : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with random latency plus a program-order
// scoreboard (decode must see consecutive PCs, restarting at each redirect target).
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_insn;
    logic [31:0] id_pc;

    fetch_stage #(
        .ADDR_W(32), .INSN_W(32), .QUEUE_DEPTH(2), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_insn(id_insn), .id_pc(id_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];
    logic [31:0] key;
    logic [31:0] exp_pc;
    logic [31:0] held_pc, held_insn;
    int          cyc, last_due, lat_min, lat_max, ready_pct;
    bit          hold_pending, prev_redirect;
    int          checks, errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] image(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ key;
    endfunction

    // One clock: memory drives its response, handshakes are sampled, scoreboard updated.
    task automatic cycle();
        bit acc, pop, resp;
        int lat, due;
        if (rst && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = image(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        imem_req_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        #1;
        if (prev_redirect) begin
            checks++;
            if (id_valid !== 1'b0) begin
                errors++;
                $display("FAIL id_valid_after_redirect: got %b required 0", id_valid);
            end
        end
        if (hold_pending && rst) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== held_pc || id_insn !== held_insn) begin
                errors++;
                $display("FAIL hold_stable: got v=%b pc=%h insn=%h required v=1 pc=%h insn=%h",
                         id_valid, id_pc, id_insn, held_pc, held_insn);
            end
        end
        acc  = imem_req_valid && imem_req_ready;
        pop  = id_valid && id_ready;
        resp = imem_resp_valid;
        if (pop) begin
            checks++;
            if (id_pc !== exp_pc || id_insn !== image(exp_pc)) begin
                errors++;
                $display("FAIL decode_order: got pc=%h insn=%h required pc=%h insn=%h",
                         id_pc, id_insn, exp_pc, image(exp_pc));
            end
            pop_log.push_back(id_pc);
            exp_pc = exp_pc + 32'd4;
        end
        hold_pending  = rst && id_valid && !id_ready && !redirect_valid;
        held_pc       = id_pc;
        held_insn     = id_insn;
        prev_redirect = rst && redirect_valid;
        if (!rst) begin
            mem_q.delete();
            exp_pc   = RESET_PC;
            last_due = cyc;
        end else begin
            if (resp) void'(mem_q.pop_front());
            if (acc) begin
                lat = $urandom_range(lat_min, lat_max);
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: imem_req_addr, due: due});
                acc_log.push_back(imem_req_addr);
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_insn !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: got req=%b idv=%b pc=%h insn=%h required 0 0 0 0",
                         imem_req_valid, id_valid, id_pc, id_insn);
            end
            cycle();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_request: got req=%b addr=%h idv=%b required 1 %h 0",
                     imem_req_valid, imem_req_addr, id_valid, RESET_PC);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL id_before_resp: got %b required 0", id_valid);
        end
        cycle();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin
            errors++;
            $display("FAIL first_id: got v=%b pc=%h required 1 %h", id_valid, id_pc, RESET_PC);
        end
    endtask

    task automatic test_stream();
        bit found = 0;
        lat_min = 1; lat_max = 1; ready_pct = 100; id_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 10 && !found; i++) begin
            if (id_valid) found = 1;
            else cycle();
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(k * 4) || id_insn !== image(32'(k * 4))) begin
                errors++;
                $display("FAIL stream: got v=%b pc=%h insn=%h required 1 %h %h",
                         id_valid, id_pc, id_insn, 32'(k * 4), image(32'(k * 4)));
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        int n0;
        id_ready = 1'b0;
        n0 = acc_log.size();
        for (int i = 0; i < 10; i++) cycle();
        checks++;
        if (imem_req_valid !== 1'b0 || acc_log.size() != n0 || id_valid !== 1'b1 || mem_q.size() != 0) begin
            errors++;
            $display("FAIL stall_credit: got req=%b new_acc=%0d idv=%b inflight=%0d required 0 0 1 0",
                     imem_req_valid, acc_log.size() - n0, id_valid, mem_q.size());
        end
        pop_log.delete();
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        checks++;
        if (pop_log.size() < 6) begin
            errors++;
            $display("FAIL stall_release: got %0d pops required at least 6", pop_log.size());
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        lat_min = 4; lat_max = 4; ready_pct = 100; id_ready = 1'b1;
        do_reset(1);
        for (int i = 0; i < 30 && !found; i++) begin
            if (mem_q.size() == 2 && mem_q[0].addr == 32'h8) found = 1;
            else cycle();
        end
        checks++;
        if (!found || mem_q[1].addr !== 32'hC) begin
            errors++;
            $display("FAIL inflight_setup: got found=%b inflight=%0d required two requests 8,C",
                     found, mem_q.size());
        end
        acc_log.delete();
        pop_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_on_redirect: got %b required 0", imem_req_valid);
        end
        cycle();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pop_log.size() >= 2) found = 1;
            else cycle();
        end
        checks++;
        if (!found || acc_log[0] !== 32'h100 || pop_log[0] !== 32'h100 || pop_log[1] !== 32'h104) begin
            errors++;
            $display("FAIL redirect_drop: got found=%b req=%h id=%h,%h required 100 100,104",
                     found, acc_log.size() ? acc_log[0] : 32'hx,
                     pop_log.size() ? pop_log[0] : 32'hx, pop_log.size() > 1 ? pop_log[1] : 32'hx);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit found = 0;
        logic [31:0] tgt;
        lat_min = 2; lat_max = 2; ready_pct = 100; id_ready = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_q.size() != 0 && mem_q[0].due <= cyc && id_valid) found = 1;
            else cycle();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL same_cycle_setup: got no resp+pop cycle required one within 40");
        end
        tgt = 32'h0000_4000 | ($urandom & 32'h0000_0FFF);
        pop_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        cycle();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pop_log.size() >= 3) found = 1;
            else cycle();
        end
        checks++;
        if (!found || pop_log[1] !== (tgt & ~32'd3) || pop_log[2] !== (tgt & ~32'd3) + 32'd4) begin
            errors++;
            $display("FAIL same_cycle_redirect: got found=%b pops=%0d required target %h then %h",
                     found, pop_log.size(), tgt & ~32'd3, (tgt & ~32'd3) + 32'd4);
        end
    endtask

    task automatic test_reset_midop_and_wrap();
        bit found = 0;
        lat_min = 3; lat_max = 3; ready_pct = 100; id_ready = 1'b0;
        do_reset(1);
        for (int i = 0; i < 20 && !found; i++) begin
            if (id_valid && mem_q.size() == 1) found = 1;
            else cycle();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midop_setup: got no buffered+inflight state required one within 20");
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (id_valid !== 1'b0 || imem_req_valid !== 1'b0 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL midop_reset: got idv=%b req=%b pc=%h required 0 0 0",
                     id_valid, imem_req_valid, id_pc);
        end
        cycle();
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL midop_release: got req=%b addr=%h required 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
        lat_min = 1; lat_max = 1; id_ready = 1'b1;
        pop_log.delete();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        cycle();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pop_log.size() >= 4) found = 1;
            else cycle();
        end
        checks++;
        if (!found || pop_log[0] !== 32'hFFFF_FFF8 || pop_log[1] !== 32'hFFFF_FFFC ||
            pop_log[2] !== 32'h0 || pop_log[3] !== 32'h4) begin
            errors++;
            $display("FAIL pc_wrap: got found=%b pops=%0d required FFFFFFF8,FFFFFFFC,0,4",
                     found, pop_log.size());
        end
    endtask

    task automatic test_random();
        int n0;
        lat_min = 1; lat_max = 3; ready_pct = 70;
        n0 = 0;
        pop_log.delete();
        for (int i = 0; i < 1500; i++) begin
            id_ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
                n0++;
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        redirect_valid = 1'b0;
        checks++;
        if (pop_log.size() < 300) begin
            errors++;
            $display("FAIL random_progress: got %0d pops (%0d redirects) required at least 300",
                     pop_log.size(), n0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; last_due = 0;
        hold_pending = 0; prev_redirect = 0;
        key = $urandom;
        exp_pc = RESET_PC;
        rst = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_reset_midop_and_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
